// File: rtl/cordic_pkg.sv
// Shared types and constant helpers for the iterative CORDIC engine.
// Angles are binary: 2^(w-1) is pi, 2^(w-2) is pi/2.
// atan_const() is for elaboration-time table generation only.
package cordic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    ROT = 1'b0,
    VEC = 1'b1
  } mode_t;

  // pi in w-bit binary angle units; as a signed w-bit value this is -pi,
  // which is the same point on the circle.
  function automatic int pi_const(int w);
    return 1 << (w - 1);
  endfunction

  function automatic int half_pi_const(int w);
    return 1 << (w - 2);
  endfunction

  // round(atan(2^-i) / pi * 2^(w-1))
  function automatic int atan_const(int i, int w);
    real r;
    r = $atan(1.0 / (2.0 ** i)) / 3.14159265358979323846 * (2.0 ** (w - 1));
    return $rtoi(r + 0.5);
  endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent table for the CORDIC micro-rotations.
// Ports:
//   idx  in  IW  micro-rotation index i
//   atan out W   round(atan(2^-i)/pi * 2^(W-1)); 0 for i >= ITER
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int W    = 16,
  parameter int ITER = 15,
  parameter int IW   = $clog2(ITER + 1)
) (
  input  logic [IW-1:0] idx,
  output logic [W-1:0]  atan
);

  // Table is padded to the full index range so any idx is a legal lookup.
  logic [W-1:0] table_w [2**IW];

  for (genvar g = 0; g < 2**IW; g++) begin : g_tab
    if (g < ITER) begin : g_val
      assign table_w[g] = W'(atan_const(g, W));
    end else begin : g_pad
      assign table_w[g] = '0;
    end
  end

  always_comb begin
    atan = table_w[idx];
  end

endmodule

// File: rtl/cordic_iter.sv
// Iterative CORDIC engine, one micro-rotation per clock.
// Rotation mode drives z to 0 (sin/cos, vector rotate); vectoring mode
// drives y to 0 (magnitude/atan2). Gain K ~ 1.6468 is not compensated.
// Ports:
//   clock, reset_n          rising-edge clock, async active-low reset
//   start, mode             request (taken when ready=1), 0=rotation 1=vectoring
//   x_in, y_in, z_in        signed operands / binary angle (W bits)
//   ready, busy, done       handshake; done is a one-cycle result-valid pulse
//   x_out, y_out            saturated results; z_out wraps mod 2^W
//
// state | meaning
// IDLE  | waiting for start, ready=1
// RUN   | micro-rotations i=0..ITER-1, then one cycle to register outputs
// DONE  | results valid for one cycle, ready=1, start re-accepted here
module cordic_iter
  import cordic_pkg::*;
#(
  parameter int W    = 16,
  parameter int ITER = 15,
  parameter int GRD  = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic                mode,
  input  logic signed [W-1:0] x_in,
  input  logic signed [W-1:0] y_in,
  input  logic signed [W-1:0] z_in,
  output logic                ready,
  output logic                busy,
  output logic                done,
  output logic signed [W-1:0] x_out,
  output logic signed [W-1:0] y_out,
  output logic signed [W-1:0] z_out
);

  localparam int DW = W + GRD;
  localparam int CW = $clog2(ITER + 1);
  localparam logic signed [W-1:0]  HALF_PI = W'(half_pi_const(W));
  localparam logic [W-1:0]         PI_W    = W'(pi_const(W));
  localparam logic signed [DW-1:0] SAT_MAX = DW'((1 << (W - 1)) - 1);
  localparam logic signed [DW-1:0] SAT_MIN = ~SAT_MAX;

  state_t               state_q, state_d;
  mode_t                mode_q, mode_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic signed [DW-1:0] x_q, x_d, y_q, y_d;
  logic signed [W-1:0]  z_q, z_d;
  logic                 ready_q, ready_d, busy_q, busy_d, done_q, done_d;
  logic signed [W-1:0]  x_out_q, x_out_d, y_out_q, y_out_d, z_out_q, z_out_d;

  logic [W-1:0]         atan_i;
  logic signed [DW-1:0] x_ext, y_ext, x_sh, y_sh;
  logic                 pre_neg, dir;
  logic signed [W-1:0]  z_pre;

  cordic_atan_rom #(.W(W), .ITER(ITER), .IW(CW)) u_rom (
    .idx  (cnt_q),
    .atan (atan_i)
  );

  function automatic logic signed [W-1:0] sat(input logic signed [DW-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[W-1:0];
    else if (v < SAT_MIN) return SAT_MIN[W-1:0];
    else                  return v[W-1:0];
  endfunction

  always_comb begin
    x_ext = {{GRD{x_in[W-1]}}, x_in};
    y_ext = {{GRD{y_in[W-1]}}, y_in};

    // Pre-rotation by pi brings the operand into the CORDIC convergence range.
    // Adding or subtracting pi is the same thing mod 2^W.
    pre_neg = 1'b0;
    z_pre   = z_in;
    if (mode_t'(mode) == ROT) begin
      if ((z_in > HALF_PI) || (z_in < -HALF_PI)) begin
        pre_neg = 1'b1;
        z_pre   = z_in - PI_W;
      end
    end else if (x_in[W-1]) begin
      pre_neg = 1'b1;
      z_pre   = z_in + PI_W;
    end

    x_sh = x_q >>> cnt_q;
    y_sh = y_q >>> cnt_q;
    dir  = (mode_q == ROT) ? ~z_q[W-1] : y_q[DW-1];

    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    x_out_d = x_out_q;
    y_out_d = y_out_q;
    z_out_d = z_out_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (start) begin
          state_d = RUN;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          mode_d  = mode_t'(mode);
          cnt_d   = '0;
          x_d     = pre_neg ? -x_ext : x_ext;
          y_d     = pre_neg ? -y_ext : y_ext;
          z_d     = z_pre;
        end
      end
      RUN: begin
        if (cnt_q == CW'(ITER)) begin
          state_d = DONE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          x_out_d = sat(x_q);
          y_out_d = sat(y_q);
          z_out_d = z_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (dir) begin
            x_d = x_q - y_sh;
            y_d = y_q + x_sh;
            z_d = z_q - atan_i;
          end else begin
            x_d = x_q + y_sh;
            y_d = y_q - x_sh;
            z_d = z_q + atan_i;
          end
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mode_q  <= ROT;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      x_out_q <= '0;
      y_out_q <= '0;
      z_out_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      x_out_q <= x_out_d;
      y_out_q <= y_out_d;
      z_out_q <= z_out_d;
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign x_out = x_out_q;
  assign y_out = y_out_q;
  assign z_out = z_out_q;

endmodule
